// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-cycle PC/pipeline-register write enables and
// bubble inserts for load-use, taken branch, memory stalls and HLT drain.
module pipe_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             id_branch_taken,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
    logic ifid_fl;
    logic idex_fl;
  } ctrl_t;

  localparam ctrl_t C_IDLE    = '0;
  localparam ctrl_t C_ADVANCE = 7'b1111100;
  localparam ctrl_t C_LU      = 7'b0011101;
  localparam ctrl_t C_BRANCH  = 7'b1111110;
  localparam ctrl_t C_HOLDPC  = 7'b0111110;
  localparam ctrl_t C_DRHOLD  = 7'b0000010;
  localparam ctrl_t C_DRADV   = 7'b0111111;

  state_t          state, state_nxt;
  logic [DW-1:0]   drain_cnt, drain_nxt;
  logic [CNT_W-1:0] cnt;
  ctrl_t           c;
  logic            rs_hit, rt_hit, lu;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);
  assign lu     = ex_memrd && (ex_rd != '0) && (rs_hit || rt_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    c         = C_IDLE;
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      RUN: begin
        if (dmem_busy)            c = C_IDLE;
        else if (lu)              c = C_LU;
        // a taken branch discards any in-flight fetch, so imem_busy cannot hold the PC
        else if (id_branch_taken) c = C_BRANCH;
        else if (id_halt) begin
          c         = C_HOLDPC;
          state_nxt = DRAIN;
          drain_nxt = DW'(DRAIN_CYCLES);
        end
        else if (imem_busy)       c = C_HOLDPC;
        else                      c = C_ADVANCE;
      end
      DRAIN: begin
        if (dmem_busy) c = C_DRHOLD;
        else begin
          c         = C_DRADV;
          drain_nxt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) state_nxt = HALTED;
        end
      end
      HALTED:  c = C_IDLE;
      default: begin
        c         = C_IDLE;
        state_nxt = RUN;
      end
    endcase
  end

  // Controls are forced quiet for the whole time reset is held.
  assign pc_wen     = rst & c.pc;
  assign ifid_wen   = rst & c.ifid;
  assign idex_wen   = rst & c.idex;
  assign exmem_wen  = rst & c.exmem;
  assign memwb_wen  = rst & c.memwb;
  assign ifid_flush = rst & c.ifid_fl;
  assign idex_flush = rst & c.idex_fl;
  assign halted     = (state == HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  cnt <= '0;
    else if (state == RUN && !c.pc && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end

  assign stall_cycles = cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized + directed bench for pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
  localparam int REG_W = 4;
  localparam int DC    = 3;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [REG_W-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, id_halt = 0, id_branch_taken = 0;
  logic ex_memrd = 0, imem_busy = 0, dmem_busy = 0;
  logic pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush, halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [6:0] got;

  pipe_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_halt(id_halt), .id_branch_taken(id_branch_taken),
    .ex_memrd(ex_memrd), .ex_rd(ex_rd), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .pc_wen(pc_wen), .ifid_wen(ifid_wen), .idex_wen(idex_wen), .exmem_wen(exmem_wen),
    .memwb_wen(memwb_wen), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign got = {pc_wen, ifid_wen, idex_wen, exmem_wen, memwb_wen, ifid_flush, idex_flush};

  int checks = 0;
  int errors = 0;
  // model: 0 = running, 1 = draining, 2 = stopped
  int m_state = 0, m_drain = 0, m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit lu_f();
    return ex_memrd && ex_rd != 0 &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
  function automatic logic [6:0] m_exp();
    if (!rst || m_state == 2) return 7'b0000000;
    if (m_state == 1) return dmem_busy ? 7'b0000010 : 7'b0111111;
    if (dmem_busy)       return 7'b0000000;
    if (lu_f())          return 7'b0011101;
    if (id_branch_taken) return 7'b1111110;
    if (id_halt)         return 7'b0111110;
    if (imem_busy)       return 7'b0111110;
    return 7'b1111100;
  endfunction

  // Compare current cycle against the model, then advance the model across the edge.
  task automatic step();
    logic [6:0] e;
    if (!rst) begin m_state = 0; m_drain = 0; m_cnt = 0; end
    #1;
    e = m_exp();
    chk("ctrl", 32'(got), 32'(e));
    chk("halted", 32'(halted), 32'(m_state == 2));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      if (m_state == 0) begin
        if (!e[6] && m_cnt < CMAX) m_cnt++;
        if (!dmem_busy && !lu_f() && !id_branch_taken && id_halt) begin
          m_state = 1;
          m_drain = DC;
        end
      end else if (m_state == 1 && !dmem_busy) begin
        if (m_drain == 1) m_state = 2;
        m_drain--;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_halt = 0; id_branch_taken = 0; ex_memrd = 0; imem_busy = 0; dmem_busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic rand_inputs();
    id_rs = REG_W'($urandom_range(0, 3));
    id_rt = REG_W'($urandom_range(0, 3));
    ex_rd = REG_W'($urandom_range(0, 3));
    id_uses_rs = 1'($urandom_range(0, 1));
    id_uses_rt = 1'($urandom_range(0, 1));
    ex_memrd = ($urandom_range(0, 2) == 0);
    id_halt = ($urandom_range(0, 39) == 0);
    id_branch_taken = ($urandom_range(0, 5) == 0);
    imem_busy = ($urandom_range(0, 3) == 0);
    dmem_busy = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    do_reset();

    // load-use hazard costs one bubble
    ex_memrd = 1; ex_rd = 3; id_uses_rs = 1; id_rs = 3;
    #1;
    chk("lu_pc_wen", 32'(pc_wen), 0);
    chk("lu_ifid_wen", 32'(ifid_wen), 0);
    chk("lu_idex_flush", 32'(idex_flush), 1);
    step();
    idle_inputs();
    #1 chk("lu_released", 32'(pc_wen), 1);
    step();
    ex_memrd = 1; ex_rd = 0; id_uses_rs = 1; id_rs = 0;
    #1;
    chk("lu_r0_pc_wen", 32'(pc_wen), 1);
    chk("lu_r0_idex_flush", 32'(idex_flush), 0);
    step();

    // priority: dmem freeze over load-use and branch
    do_reset();
    dmem_busy = 1; ex_memrd = 1; ex_rd = 2; id_uses_rt = 1; id_rt = 2; id_branch_taken = 1;
    #1 chk("prio_freeze", 32'(got), 0);
    step();
    idle_inputs();
    #1 chk("prio_stall_cnt", 32'(stall_cycles), 1);
    id_branch_taken = 1; imem_busy = 1;
    #1 chk("br_over_imem", 32'(got), 32'(7'b1111110));
    step();

    // HLT drain without stalls
    do_reset();
    for (int c = 0; c < 17; c++) begin
      idle_inputs();
      id_halt = (c == 10);
      if (c >= 15) rand_inputs();
      #1;
      if (c == 10) chk("hlt_pc_wen", 32'(pc_wen), 0);
      if (c == 13) chk("hlt_not_yet", 32'(halted), 0);
      if (c == 14) chk("hlt_halted", 32'(halted), 1);
      if (c == 15) chk("hlt_frozen", 32'(got), 0);
      step();
    end

    // HLT drain with memory stall in cycles 12-13
    do_reset();
    for (int c = 0; c < 18; c++) begin
      idle_inputs();
      id_halt = (c == 10);
      dmem_busy = (c == 12 || c == 13);
      #1;
      if (c == 12 || c == 13) chk("drain_hold", 32'(got), 32'(7'b0000010));
      if (c == 15) chk("drain_not_yet", 32'(halted), 0);
      if (c == 16) chk("drain_halted", 32'(halted), 1);
      step();
    end

    // counter saturation
    do_reset();
    for (int c = 0; c < 20; c++) begin
      idle_inputs();
      imem_busy = 1;
      #1;
      if (c == 5)  chk("sat_cnt5", 32'(stall_cycles), 5);
      if (c == 15) chk("sat_cnt15", 32'(stall_cycles), 15);
      if (c == 19) chk("sat_hold", 32'(stall_cycles), 15);
      step();
    end

    // async reset in the middle of a drain
    do_reset();
    imem_busy = 1; step(); step();
    idle_inputs(); id_halt = 1; step();
    idle_inputs(); step();
    rst = 1'b0;
    #1;
    chk("arst_ctrl", 32'(got), 0);
    chk("arst_halted", 32'(halted), 0);
    chk("arst_cnt", 32'(stall_cycles), 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 if (c == 4) chk("arst_run", 32'(got), 32'(7'b1111100));
      step();
    end

    // randomized run with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 149) != 0);
      step();
    end
    rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage pipelined processor. Each cycle it generates the write-enable and flush (bubble-insert) controls for the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), all of which are built from write-enabled flip-flops. It resolves load-use hazards, taken branches, multi-cycle instruction and data memory stalls, and HLT drain. It also keeps a saturating stall-cycle counter.

## Interface
- REG_W, 4, register-specifier width; register 0 is hardwired zero
- DRAIN_CYCLES, 3, advancing cycles after HLT leaves ID before the pipeline is empty
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- id_rs, id_rt  in  REG_W  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  instruction in ID reads id_rs / id_rt
- id_halt  in  1  instruction in ID is HLT
- id_branch_taken  in  1  branch in ID resolved taken
- ex_memrd  in  1  instruction in EX is a load
- ex_rd  in  REG_W  destination register of the instruction in EX
- imem_busy  in  1  instruction fetch not complete this cycle
- dmem_busy  in  1  data access in MEM not complete this cycle
- pc_wen  out  1  PC update enable
- ifid_wen, idex_wen, exmem_wen, memwb_wen  out  1  pipeline register write enables
- ifid_flush, idex_flush  out  1  load NOP into IF/ID / ID/EX instead of the incoming data; only meaningful with the matching wen=1
- halted  out  1  processor stopped
- stall_cycles  out  CNT_W  count of RUN cycles with pc_wen=0, saturating

## Operation
- States: RUN, DRAIN, HALTED. Reset sets state=RUN, drain_cnt=0, stall_cycles=0.
- While rst=0: all wen and flush outputs are 0, and halted=0.
- Definition: lu = ex_memrd & (ex_rd≠0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- RUN control, first match wins:
  1. dmem_busy: all five wen=0 and both flushes=0. Full freeze.
  2. lu: pc_wen=0, ifid_wen=0, idex_wen=1, idex_flush=1, exmem_wen=memwb_wen=1.
  3. id_branch_taken: all wen=1, ifid_flush=1. The PC redirects and any pending fetch is discarded, including when imem_busy=1.
  4. id_halt: all wen=1, pc_wen=0, ifid_flush=1. Next state is DRAIN with drain_cnt=DRAIN_CYCLES.
  5. imem_busy: pc_wen=0, ifid_flush=1, all other wen=1.
  6. Otherwise: all wen=1, flushes=0.
- DRAIN:
  - pc_wen=0 and ifid_flush=1.
  - If dmem_busy=1: all wen=0 and drain_cnt holds.
  - If dmem_busy=0: ifid/idex/exmem/memwb wen=1, idex_flush=1, and drain_cnt decrements.
  - On the advancing cycle with drain_cnt==1, next state is HALTED.
  - All other inputs are ignored.
- HALTED: all wen=0, flushes=0, halted=1. The only exit is reset.
- stall_cycles increments by 1 on each RUN clock edge where pc_wen=0. It saturates at 2^CNT_W−1 and never wraps. It does not count in DRAIN or HALTED.
- Reset asserted mid-DRAIN or mid-stall: the next state after release is RUN with the counter at 0.

## Timing
- All control outputs are combinational from current state and inputs, valid within the same cycle. There are no registered outputs except halted and stall_cycles.
- halted is a decode of state: it rises the cycle after the final drain advance.
- State, drain_cnt and stall_cycles update on the rising clk edge. rst low clears them immediately, independent of clk.
- Load-use costs exactly one bubble, assuming the EX load advances; the stall is removed the next cycle.
- HLT accepted in ID at cycle T: halted=1 from cycle T+1+DRAIN_CYCLES, plus one cycle for each DRAIN cycle with dmem_busy=1.

## Test plan
- Load-use: ex_memrd=1, ex_rd=3, id_uses_rs=1, id_rs=3 → pc_wen=0, ifid_wen=0, idex_flush=1 for one cycle. Repeat with ex_rd=0 → no stall.
- Priority: dmem_busy=1 together with lu=1 and id_branch_taken=1 → all wen=0 and stall_cycles+1. Then id_branch_taken=1 with imem_busy=1 → pc_wen=1, ifid_flush=1.
- HLT drain: id_halt=1 at cycle 10 with no stalls → pc_wen=0 from cycle 10, halted=1 at cycle 14, then all wen=0 regardless of inputs.
- Drain with memory stall: HLT at cycle 10 and dmem_busy=1 in cycles 12–13 → halted=1 at cycle 16, and wen=0 during cycles 12–13.
- Counter saturation with CNT_W=4: hold imem_busy=1 for 20 cycles → stall_cycles reaches 15 and stays at 15.
- Async reset: drop rst mid-edge in DRAIN → outputs go to 0 immediately and halted=0. After release, state is RUN and stall_cycles=0.
